shared_reg_arbiter: RTL and testbench

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_arbiter.sv | 114 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter guarding a single shared storage
// register. Each accepted request produces a one-cycle grant, commits the
// granted requester's data slice to q at the end of that cycle, then spends
// one recovery cycle before the next arbitration.
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic                    busy,
    output logic [7:0]              wr_count
);

    localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned N  = NREQ;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       ptr, ptr_nx;
    logic [IW-1:0]       sel, sel_nx;
    logic [NREQ-1:0]     gnt_nx;
    logic [WIDTH-1:0]    q_nx;
    logic                busy_nx;
    logic [7:0]          cnt_nx;

    logic [IW-1:0]       pick;
    logic                found;
    int unsigned         idx;

    // Cyclic search for the first active request starting at ptr.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    // Next-state and next registered-output logic.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        gnt_nx   = '0;
        busy_nx  = 1'b0;
        q_nx     = q;
        cnt_nx   = wr_count;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    sel_nx   = pick;
                    gnt_nx   = NREQ'(1) << pick;
                    busy_nx  = 1'b1;
                end
            end
            GRANT: begin
                // Data is taken at the end of the grant cycle, whether or
                // not the requester still holds req.
                q_nx     = wdata[sel*WIDTH +: WIDTH];
                cnt_nx   = wr_count + 8'd1;
                ptr_nx   = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
                state_nx = RECOVER;
                busy_nx  = 1'b1;
            end
            RECOVER: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            ptr      <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            q        <= '0;
            wr_count <= '0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            ptr      <= ptr_nx;
            gnt      <= gnt_nx;
            busy     <= busy_nx;
            q        <= q_nx;
            wr_count <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NREQ=4, WIDTH=8) with a scoreboard
// of expected grant / data / count per write.
module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        busy;
    logic [7:0]  wr_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];

    shared_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .q        (q),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] d, input logic [7:0] c);
        exp_t e;
        e.g = g;
        e.d = d;
        e.c = c;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a grant, then checks the grant, commit and recovery.
    task automatic do_grant(input string tag, input logic [3:0] req_after,
                            input logic [31:0] wd_after);
        int   waited;
        exp_t e;
        waited = 0;
        while (gnt === 4'b0 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        req   = req_after;
        wdata = wd_after;
        e = sb.pop_front();
        chk({tag, ":gnt"}, 32'(gnt), 32'(e.g));
        chk({tag, ":wait"}, 32'(waited), 32'd1);
        chk({tag, ":busy_g"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, ":gnt_r"}, 32'(gnt), 32'd0);
        chk({tag, ":busy_r"}, 32'(busy), 32'd1);
        chk({tag, ":q"}, 32'(q), 32'(e.d));
        chk({tag, ":cnt"}, 32'(wr_count), 32'(e.c));
        @(posedge clk);
        #1;
        chk({tag, ":busy_i"}, 32'(busy), 32'd0);
        chk({tag, ":gnt_i"}, 32'(gnt), 32'd0);
    endtask

    task automatic rst_pulse(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk({tag, ":rgnt"}, 32'(gnt), 32'd0);
        chk({tag, ":rq"}, 32'(q), 32'd0);
        chk({tag, ":rcnt"}, 32'(wr_count), 32'd0);
        chk({tag, ":rbusy"}, 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int waited;
        rst   = 1'b0;
        req   = '0;
        wdata = '0;
        #2;
        rst = 1'b1;
        #2;
        chk("reset:gnt", 32'(gnt), 32'd0);
        chk("reset:q", 32'(q), 32'd0);
        chk("reset:cnt", 32'(wr_count), 32'd0);
        chk("reset:busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with no requests stays quiet.
        @(posedge clk);
        #1;
        chk("idle:gnt", 32'(gnt), 32'd0);
        chk("idle:busy", 32'(busy), 32'd0);

        // Single write.
        wdata = 32'h0000_00A5;
        req   = 4'b0001;
        push(4'b0001, 8'hA5, 8'd1);
        do_grant("single", 4'b0000, wdata);

        // Round-robin from reset with all requesters active.
        rst_pulse("rr");
        wdata = 32'h4433_2211;
        req   = 4'b1111;
        push(4'b0001, 8'h11, 8'd1);
        push(4'b0010, 8'h22, 8'd2);
        push(4'b0100, 8'h33, 8'd3);
        push(4'b1000, 8'h44, 8'd4);
        push(4'b0001, 8'h11, 8'd5);
        do_grant("rr0", 4'b1111, wdata);
        do_grant("rr1", 4'b1111, wdata);
        do_grant("rr2", 4'b1111, wdata);
        do_grant("rr3", 4'b1111, wdata);
        do_grant("rr4", 4'b0000, wdata);

        // Pointer past the highest active request wraps to index 0.
        req = 4'b0100;
        push(4'b0100, 8'h33, 8'd6);
        push(4'b0001, 8'h11, 8'd7);
        push(4'b0010, 8'h22, 8'd8);
        do_grant("wrap2", 4'b0011, wdata);
        do_grant("wrap0", 4'b0011, wdata);
        do_grant("wrap1", 4'b0000, wdata);

        // Request dropped during GRANT; data changes mid-grant and the
        // value present at the end of GRANT is committed.
        wdata = 32'h4477_2211;
        req   = 4'b0100;
        push(4'b0100, 8'h3C, 8'd9);
        do_grant("drop", 4'b0000, 32'h443C_2211);

        // Reset in the middle of a grant aborts the write.
        req = 4'b0010;
        waited = 0;
        while (gnt === 4'b0 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("mid:gnt", 32'(gnt), 32'b0010);
        rst = 1'b1;
        #1;
        chk("mid:rgnt", 32'(gnt), 32'd0);
        chk("mid:rq", 32'(q), 32'd0);
        chk("mid:rcnt", 32'(wr_count), 32'd0);
        chk("mid:rbusy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1010;
        push(4'b0010, 8'h22, 8'd1);
        push(4'b1000, 8'h44, 8'd2);
        do_grant("post0", 4'b1000, wdata);
        do_grant("post1", 4'b0000, wdata);

        // 256 consecutive writes wrap the counter.
        rst_pulse("cw");
        req = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            wdata = 32'(i);
            push(4'b0001, 8'(i), 8'(i + 1));
            do_grant("cw", (i == 255) ? 4'b0000 : 4'b0001, wdata);
        end
        chk("cw:final_cnt", 32'(wr_count), 32'd0);
        chk("cw:final_q", 32'(q), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
